// File: rtl/alu_seq.sv
// Multi-byte add/sub/shift sequencer driving an 8-bit ALU and a byte-wide register file.
// Latency: len+1 cycles from accepted start to the done pulse. No backpressure; start while busy is dropped.
module alu_seq #(
    parameter int ADDR_W  = 4,
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              carry_flag,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [7:0]        rf_rdata_a,
    input  logic [7:0]        rf_rdata_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [7:0]        rf_wdata,
    output logic [3:0]        alu_instr,
    output logic [7:0]        alu_inA,
    output logic [7:0]        alu_inB,
    output logic              alu_direction,
    output logic              alu_use_carry,
    output logic              alu_carry_in,
    input  logic [7:0]        alu_data_out,
    input  logic              alu_carry_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] base_d_q, base_d_d;
    logic              carry_q, carry_d;
    logic              err_q, err_d;
    logic              cflag_q, cflag_d;

    logic              len_ok;
    logic              exec;
    logic              first_byte;
    logic              last_byte;
    logic [LEN_W-1:0]  idx;

    assign len_ok     = (len != '0) && (len <= MAX_LEN_C);
    assign exec       = (state_q == S_EXEC);
    assign first_byte = (cnt_q == '0);
    assign last_byte  = (cnt_q == len_q - ONE_C);
    // SHR walks from the MS byte down so the shifted-out bit flows towards byte 0.
    assign idx        = (op_q == OP_SHR) ? (len_q - ONE_C - cnt_q) : cnt_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_d_d = base_d_q;
        carry_d  = carry_q;
        err_d    = err_q;
        cflag_d  = cflag_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = !len_ok;
                    if (len_ok) begin
                        op_d     = op;
                        len_d    = len;
                        base_a_d = base_a;
                        base_b_d = base_b;
                        base_d_d = base_d;
                        carry_d  = 1'b0;
                        cflag_d  = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_EXEC;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                carry_d = alu_carry_out;
                cnt_d   = cnt_q + ONE_C;
                if (last_byte) begin
                    cflag_d = alu_carry_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            len_q    <= '0;
            cnt_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            cflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            cflag_q  <= cflag_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign carry_flag = cflag_q;

    // Datapath outputs are purely combinational from state so reset forces them to idle values at once.
    always_comb begin
        rf_raddr_a    = '0;
        rf_raddr_b    = '0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        alu_instr     = 4'd15;
        alu_inA       = '0;
        alu_inB       = '0;
        alu_direction = 1'b0;
        alu_use_carry = 1'b0;
        alu_carry_in  = 1'b0;
        if (exec) begin
            rf_raddr_a = base_a_q + ADDR_W'(idx);
            rf_raddr_b = base_b_q + ADDR_W'(idx);
            rf_waddr   = base_d_q + ADDR_W'(idx);
            rf_we      = 1'b1;
            rf_wdata   = alu_data_out;
            alu_inA    = rf_rdata_a;
            case (op_q)
                OP_ADD: begin
                    alu_instr    = 4'd2;
                    alu_inB      = rf_rdata_b;
                    alu_carry_in = carry_q;
                end
                OP_SUB: begin
                    alu_instr    = 4'd2;
                    alu_inB      = ~rf_rdata_b;
                    alu_carry_in = first_byte ? 1'b1 : carry_q;
                end
                default: begin
                    alu_instr     = 4'd8;
                    alu_direction = (op_q == OP_SHL);
                    alu_use_carry = 1'b1;
                    alu_carry_in  = first_byte ? 1'b0 : carry_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU and register file.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'd0;
    logic [2:0] len = 3'd0;
    logic [3:0] base_a = 4'd0, base_b = 4'd0, base_d = 4'd0;
    logic       busy, done, err, carry_flag;
    logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic       rf_we;
    logic [3:0] alu_instr;
    logic [7:0] alu_inA, alu_inB, alu_data_out;
    logic       alu_direction, alu_use_carry, alu_carry_in, alu_carry_out;

    logic [7:0] rf [16];
    logic       tb_we = 1'b0;
    logic [3:0] tb_addr = 4'd0;
    logic [7:0] tb_dat = 8'd0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [3:0] wlog [$];
    logic [3:0] rlog [$];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_seq #(.ADDR_W(4), .MAX_LEN(4), .LEN_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
        .base_a(base_a), .base_b(base_b), .base_d(base_d),
        .busy(busy), .done(done), .err(err), .carry_flag(carry_flag),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_instr(alu_instr), .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_direction(alu_direction), .alu_use_carry(alu_use_carry),
        .alu_carry_in(alu_carry_in), .alu_data_out(alu_data_out),
        .alu_carry_out(alu_carry_out)
    );

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always_comb begin
        alu_data_out  = 8'd0;
        alu_carry_out = 1'b0;
        if (alu_instr == 4'd2) begin
            {alu_carry_out, alu_data_out} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'd0, alu_carry_in};
        end else if (alu_instr == 4'd8) begin
            if (alu_direction) begin
                alu_data_out  = {alu_inA[6:0], alu_use_carry & alu_carry_in};
                alu_carry_out = alu_inA[7];
            end else begin
                alu_data_out  = {alu_use_carry & alu_carry_in, alu_inA[7:1]};
                alu_carry_out = alu_inA[0];
            end
        end
    end

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            wr_cnt <= wr_cnt + 1;
            wlog.push_back(rf_waddr);
            rlog.push_back(rf_raddr_a);
        end else if (tb_we) begin
            rf[tb_addr] <= tb_dat;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_dat = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [2:0] l,
                         input logic [3:0] ba, input logic [3:0] bb, input logic [3:0] bd);
        @(negedge clk);
        start = 1'b1; op = o; len = l; base_a = ba; base_b = bb; base_d = bd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called one step after the accepting edge: that is cycle 1.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc = 1; bcyc = 0;
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) bcyc++;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Runs a command; returns done cycle, busy cycles and err/carry_flag sampled in the done cycle.
    task automatic run(input logic [1:0] o, input logic [2:0] l, input logic [3:0] ba,
                       input logic [3:0] bb, input logic [3:0] bd,
                       output int cyc, output int bcyc, output logic e, output logic c);
        issue(o, l, ba, bb, bd);
        wait_done(cyc, bcyc);
        e = err; c = carry_flag;
        @(posedge clk); #1;
        chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    endtask

    int         cyc, bcyc, w0, d0, wl0;
    logic       e, c;

    initial begin
        #2;
        chk("rst_flags", {27'd0, busy, done, err, carry_flag, rf_we}, 32'd0);
        chk("rst_alu", {20'd0, alu_instr, alu_inA}, {20'd0, 4'd15, 8'd0});
        chk("rst_addr", {20'd0, rf_raddr_a, rf_raddr_b, rf_waddr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // ADD 0x00FF + 0x0001
        poke(0, 8'hFF); poke(1, 8'h00); poke(2, 8'h01); poke(3, 8'h00);
        run(2'b00, 3'd2, 4'd0, 4'd2, 4'd4, cyc, bcyc, e, c);
        chk("add_done_cyc", cyc, 3);
        chk("add_busy_cycles", bcyc, 3);
        chk("add_flags", {30'd0, e, c}, 32'd0);
        chk("add_result", {16'd0, rf[5], rf[4]}, 32'h0100);

        // SUB 0x0100 - 0x0001, then 0x0000 - 0x0001
        poke(0, 8'h00); poke(1, 8'h01);
        run(2'b01, 3'd2, 4'd0, 4'd2, 4'd4, cyc, bcyc, e, c);
        chk("sub1_result", {16'd0, rf[5], rf[4]}, 32'h00FF);
        chk("sub1_carry", {31'd0, c}, 32'd1);
        poke(1, 8'h00);
        run(2'b01, 3'd2, 4'd0, 4'd2, 4'd4, cyc, bcyc, e, c);
        chk("sub2_result", {16'd0, rf[5], rf[4]}, 32'hFFFF);
        chk("sub2_carry", {31'd0, c}, 32'd0);

        // SHL 0x8001 and SHR 0x0181
        poke(0, 8'h01); poke(1, 8'h80);
        run(2'b10, 3'd2, 4'd0, 4'd0, 4'd6, cyc, bcyc, e, c);
        chk("shl_result", {16'd0, rf[7], rf[6]}, 32'h0002);
        chk("shl_carry", {31'd0, c}, 32'd1);
        poke(0, 8'h81); poke(1, 8'h01);
        wl0 = wlog.size();
        run(2'b11, 3'd2, 4'd0, 4'd0, 4'd8, cyc, bcyc, e, c);
        chk("shr_result", {16'd0, rf[9], rf[8]}, 32'h00C0);
        chk("shr_carry", {31'd0, c}, 32'd1);
        chk("shr_wr_order", {24'd0, wlog[wl0], wlog[wl0+1]}, {24'd0, 4'd9, 4'd8});

        // Rejected lengths: no writes, carry_flag keeps the SHR value
        w0 = wr_cnt;
        run(2'b00, 3'd0, 4'd0, 4'd2, 4'd4, cyc, bcyc, e, c);
        chk("len0_done_cyc", cyc, 1);
        chk("len0_err_cflag", {30'd0, e, c}, 32'd3);
        run(2'b00, 3'd5, 4'd0, 4'd2, 4'd4, cyc, bcyc, e, c);
        chk("len5_done_cyc", cyc, 1);
        chk("len5_err_cflag", {30'd0, e, c}, 32'd3);
        chk("err_no_writes", wr_cnt - w0, 0);

        // ADD len=4 wrapping A at 14,15,0,1 with a stray start mid-command
        poke(14, 8'h44); poke(15, 8'h33); poke(0, 8'h22); poke(1, 8'h11);
        poke(4, 8'h01); poke(5, 8'h01); poke(6, 8'h01); poke(7, 8'h01);
        poke(12, 8'h5A);
        w0 = wr_cnt; wl0 = rlog.size();
        issue(2'b00, 3'd4, 4'd14, 4'd4, 4'd8);
        issue(2'b01, 3'd1, 4'd0, 4'd0, 4'd12);
        wait_done(cyc, bcyc);
        chk("wrap_err", {31'd0, err}, 32'd0);
        chk("wrap_carry", {31'd0, carry_flag}, 32'd0);
        @(posedge clk); #1;
        chk("wrap_idle", {30'd0, done, busy}, 32'd0);
        chk("wrap_writes", wr_cnt - w0, 4);
        chk("wrap_raddr", {16'd0, rlog[wl0], rlog[wl0+1], rlog[wl0+2], rlog[wl0+3]}, 32'h0000EF01);
        chk("wrap_result", {rf[11], rf[10], rf[9], rf[8]}, 32'h12233445);
        chk("stray_start_ignored", {24'd0, rf[12]}, 32'h5A);

        // Reset after the second byte of a len=4 ADD
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b00, 3'd4, 4'd0, 4'd4, 4'd12);
        @(posedge clk); @(posedge clk); #1;
        chk("abort_pre_writes", wr_cnt - w0, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {28'd0, busy, done, err, rf_we}, 32'd0);
        chk("abort_alu_addr", {16'd0, alu_instr, rf_raddr_a, rf_waddr, 4'd0}, 32'h0000F000);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_more_writes", wr_cnt - w0, 2);
        chk("abort_no_done", done_cnt - d0, 0);
        @(negedge clk) rst_n = 1'b1;
        run(2'b00, 3'd1, 4'd0, 4'd4, 4'd13, cyc, bcyc, e, c);
        chk("post_rst_done_cyc", cyc, 2);
        chk("post_rst_result", {24'd0, rf[13]}, 32'h23);
        chk("post_rst_flags", {30'd0, e, c}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
